// File: rtl/rwm_pkg.sv
// Shared definitions for the frame-buffer RWM and its sequencer: state encoding,
// default frame size and the command-line encodings both sides must agree on.
package rwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_GAP1  = 3'd2,
        ST_WRITE = 3'd3,
        ST_GAP2  = 3'd4,
        ST_READ  = 3'd5,
        ST_FIN   = 3'd6,
        ST_ERROR = 3'd7
    } rwm_state_e;

    localparam int RWM_PIXELS = 202500;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef struct packed {
        logic enable;
        logic rw;
        logic clear;
    } rwm_cmd_t;

    localparam rwm_cmd_t CMD_IDLE = '{enable: 1'b0, rw: RW_READ, clear: 1'b0};

    // Command lines the RWM must see while the sequencer sits in a given state.
    function automatic rwm_cmd_t cmd_of(rwm_state_e s);
        case (s)
            ST_CLEAR: cmd_of = '{enable: 1'b1, rw: RW_READ,  clear: 1'b1};
            ST_WRITE: cmd_of = '{enable: 1'b1, rw: RW_WRITE, clear: 1'b0};
            ST_READ:  cmd_of = '{enable: 1'b1, rw: RW_READ,  clear: 1'b0};
            default:  cmd_of = CMD_IDLE;
        endcase
    endfunction

    function automatic logic is_active(rwm_state_e s);
        return (s == ST_CLEAR) || (s == ST_WRITE) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/rwm_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// LIMIT-th enabled cycle so the owner can abandon a stuck operation.
module rwm_watchdog #(
    parameter int LIMIT = 1048576,
    parameter int W     = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    assign expired = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/rwm_frame_ctrl.sv
// Frame transaction sequencer for the RWM: optional clear, write pass, optional
// read-out pass with pixel-count check, plus watchdog and frame counting.
module rwm_frame_ctrl
    import rwm_pkg::*;
#(
    parameter int PIXELS  = RWM_PIXELS,
    parameter int CNT_W   = 18,
    parameter int TIMEOUT = 1048576,
    parameter int TO_W    = 21,
    parameter int FRM_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cfg_clear,
    input  logic             cfg_read,
    output logic             rwm_enable,
    output logic             rwm_rw,
    output logic             rwm_clear,
    input  logic             rwm_done,
    input  logic             rwm_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [FRM_W-1:0] frame_cnt,
    output rwm_state_e       dbg_state
);

    localparam logic [CNT_W-1:0] PIX_TARGET = CNT_W'(PIXELS);

    rwm_state_e       state;
    rwm_cmd_t         cmd;
    logic             read_q;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] pix_next;
    logic             wd_active;
    logic             wd_expired;

    assign {rwm_enable, rwm_rw, rwm_clear} = cmd;
    assign dbg_state = state;

    // Every active state is entered from a gap/idle state, so holding the
    // watchdog clear outside the active states restarts it on each entry.
    assign wd_active = is_active(state);

    rwm_watchdog #(
        .LIMIT (TIMEOUT),
        .W     (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!wd_active),
        .en      (wd_active),
        .expired (wd_expired)
    );

    // Count as it will stand after this cycle, so a valid on the done cycle counts.
    always_comb begin
        pix_next = pix_cnt;
        if (rwm_valid && (pix_cnt != '1)) begin
            pix_next = pix_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd       <= CMD_IDLE;
            read_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pix_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        read_q <= cfg_read;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        if (cfg_clear) begin
                            state <= ST_CLEAR;
                            cmd   <= cmd_of(ST_CLEAR);
                        end else begin
                            state <= ST_WRITE;
                            cmd   <= cmd_of(ST_WRITE);
                        end
                    end
                end
                ST_CLEAR: begin
                    if (rwm_done) begin
                        state <= ST_GAP1;
                        cmd   <= CMD_IDLE;
                    end else if (wd_expired) begin
                        state <= ST_ERROR;
                        cmd   <= CMD_IDLE;
                        err   <= 1'b1;
                    end
                end
                ST_GAP1: begin
                    state <= ST_WRITE;
                    cmd   <= cmd_of(ST_WRITE);
                end
                ST_WRITE: begin
                    if (rwm_done) begin
                        state <= read_q ? ST_GAP2 : ST_FIN;
                        cmd   <= CMD_IDLE;
                    end else if (wd_expired) begin
                        state <= ST_ERROR;
                        cmd   <= CMD_IDLE;
                        err   <= 1'b1;
                    end
                end
                ST_GAP2: begin
                    pix_cnt <= '0;
                    state   <= ST_READ;
                    cmd     <= cmd_of(ST_READ);
                end
                ST_READ: begin
                    pix_cnt <= pix_next;
                    if (rwm_done) begin
                        cmd <= CMD_IDLE;
                        if (pix_next == PIX_TARGET) begin
                            state <= ST_FIN;
                        end else begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        state <= ST_ERROR;
                        cmd   <= CMD_IDLE;
                        err   <= 1'b1;
                    end
                end
                ST_FIN: begin
                    done      <= 1'b1;
                    frame_cnt <= frame_cnt + FRM_W'(1);
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                end
                ST_ERROR: begin
                    err   <= 1'b1;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    cmd   <= CMD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rwm_frame_ctrl.sv
// Directed bench for rwm_frame_ctrl: a behavioural RWM answers the command lines,
// per-frame expectations are queued and checked whenever a frame ends.
module tb_rwm_frame_ctrl;
    import rwm_pkg::*;

    localparam int FRM_W = 2;
    localparam int W     = 41;

    // clock / reset / DUT
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cfg_clear = 1'b0;
    logic             cfg_read = 1'b0;
    logic             rwm_done = 1'b0;
    logic             rwm_valid = 1'b0;
    logic             rwm_enable, rwm_rw, rwm_clear;
    logic             busy, done, err;
    logic [FRM_W-1:0] frame_cnt;
    rwm_state_e       dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rwm_frame_ctrl #(
        .PIXELS  (16),
        .CNT_W   (5),
        .TIMEOUT (64),
        .TO_W    (7),
        .FRM_W   (FRM_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_clear  (cfg_clear),
        .cfg_read   (cfg_read),
        .rwm_enable (rwm_enable),
        .rwm_rw     (rwm_rw),
        .rwm_clear  (rwm_clear),
        .rwm_done   (rwm_done),
        .rwm_valid  (rwm_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .frame_cnt  (frame_cnt),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // behavioural RWM: op length counted from the first cycle of each command
    int   clear_len = 4;
    int   write_len = 16;
    int   read_len = 16;
    int   skip_at = 0;
    logic inject_req = 1'b0;
    int   last_done_cyc = -100;

    initial begin : rwm_model
        int       op_cnt;
        logic [2:0] cmd_now, cmd_last;
        logic     d, v;
        op_cnt = 0;
        cmd_last = 3'b000;
        forever begin
            @(negedge clk);
            cmd_now = {rwm_enable, rwm_rw, rwm_clear};
            if (!rst_n || !rwm_enable) op_cnt = 0;
            else if (cmd_now == cmd_last) op_cnt++;
            else op_cnt = 1;
            cmd_last = cmd_now;
            d = 1'b0;
            v = 1'b0;
            if (rst_n && rwm_enable) begin
                if (rwm_clear) begin
                    d = (op_cnt == clear_len);
                end else if (rwm_rw) begin
                    d = (write_len != 0) && (op_cnt == write_len);
                end else begin
                    v = (op_cnt <= read_len) && (op_cnt != skip_at);
                    d = (op_cnt == read_len);
                end
                if (d && !rwm_clear) last_done_cyc = cyc;
            end
            rwm_done  = d | inject_req;
            rwm_valid = v;
            inject_req = 1'b0;
        end
    end

    // scoreboard: {seq[23:0], enable_cycles[7:0], quiet_cycles[3:0], done_pulses[1:0], err, frame_cnt}
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] pack_exp(logic [23:0] s, logic [7:0] e, logic [3:0] l,
                                              logic [1:0] d, logic er, logic [FRM_W-1:0] f);
        return {s, e, l, d, er, f};
    endfunction

    // monitor: per-cycle command/state coherence, per-frame summary at busy fall
    initial begin : monitor
        logic         prev_busy;
        logic [23:0]  seq;
        logic [7:0]   en_cyc;
        logic [3:0]   low_cyc;
        logic [1:0]   done_cnt;
        rwm_state_e   last_st;
        logic [2:0]   exp_cmd;
        logic [W-1:0] rec;
        prev_busy = 1'b0;
        seq = '0; en_cyc = '0; low_cyc = '0; done_cnt = '0; last_st = ST_IDLE;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
            end else begin
                case (dbg_state)
                    ST_CLEAR: exp_cmd = 3'b101;
                    ST_WRITE: exp_cmd = 3'b110;
                    ST_READ:  exp_cmd = 3'b100;
                    default:  exp_cmd = 3'b000;
                endcase
                check("cmd_lines", {rwm_enable, rwm_rw, rwm_clear}, exp_cmd);
                check("busy_vs_state", busy, dbg_state != ST_IDLE);
                if (done) begin
                    done_cnt++;
                    check("done_latency", cyc - last_done_cyc, 2);
                end
                if (busy && !prev_busy) begin
                    seq = '0; en_cyc = '0; low_cyc = '0; done_cnt = '0; last_st = ST_IDLE;
                end
                if (busy) begin
                    if (dbg_state != last_st) begin
                        seq = {seq[20:0], dbg_state};
                        last_st = dbg_state;
                    end
                    if (rwm_enable) en_cyc++;
                    else low_cyc++;
                end
                if (!busy && prev_busy) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame_end: got an unexpected frame end, expected none (t=%0t)", $time);
                    end else begin
                        rec = exp_q.pop_front();
                        check("state_seq", seq, rec[40:17]);
                        check("enable_cycles", en_cyc, rec[16:9]);
                        check("quiet_cycles", low_cyc, rec[8:5]);
                        check("done_pulses", done_cnt, rec[4:3]);
                        check("err_at_end", err, rec[2]);
                        check("frame_cnt", frame_cnt, rec[1:0]);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    // driver tasks
    task automatic issue(input logic clr, input logic rd);
        @(negedge clk);
        cfg_clear = clr;
        cfg_read  = rd;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cfg_clear = 1'b0;
        cfg_read  = 1'b0;
        check("start_to_enable", rwm_enable, 1);
        check("err_cleared_by_start", err, 0);
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    initial begin : stimulus
        int n;
        #12;
        check("rst_enable", rwm_enable, 0);
        check("rst_rw", rwm_rw, 0);
        check("rst_clear", rwm_clear, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // write then read, 16 good pixels
        write_len = 16; read_len = 16; skip_at = 0;
        exp_q.push_back(pack_exp(24'o3456, 8'd32, 4'd2, 2'd1, 1'b0, 2'd1));
        issue(1'b0, 1'b1);
        wait_idle(300);

        // clear, one gap cycle, write, no read
        clear_len = 4;
        exp_q.push_back(pack_exp(24'o1236, 8'd20, 4'd2, 2'd1, 1'b0, 2'd2));
        issue(1'b1, 1'b0);
        wait_idle(300);

        // read with one pixel missing -> error, no frame
        skip_at = 5;
        exp_q.push_back(pack_exp(24'o3457, 8'd32, 4'd2, 2'd0, 1'b1, 2'd2));
        issue(1'b0, 1'b1);
        wait_idle(300);
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1);

        // good frame clears err
        skip_at = 0;
        exp_q.push_back(pack_exp(24'o3456, 8'd32, 4'd2, 2'd1, 1'b0, 2'd3));
        issue(1'b0, 1'b1);
        wait_idle(300);

        // write never completes -> watchdog after 64 cycles
        write_len = 0;
        exp_q.push_back(pack_exp(24'o37, 8'd64, 4'd1, 2'd0, 1'b1, 2'd3));
        issue(1'b0, 1'b0);
        n = 0;
        while (rwm_enable && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_enable_dropped", rwm_enable, 0);
        check("timeout_err", err, 1);
        check("timeout_busy_hold", busy, 1);
        @(negedge clk);
        check("timeout_busy_clear", busy, 0);
        wait_idle(10);

        // spurious done in IDLE is ignored
        write_len = 16;
        inject_req = 1'b1;
        repeat (3) @(negedge clk);
        check("spurious_done_busy", busy, 0);
        check("spurious_done_frames", frame_cnt, 3);

        // start pulsed mid-frame is ignored; frame counter wraps to 0
        exp_q.push_back(pack_exp(24'o36, 8'd16, 4'd1, 2'd1, 1'b0, 2'd0));
        issue(1'b0, 1'b0);
        repeat (4) @(negedge clk);
        cfg_clear = 1'b1; cfg_read = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cfg_clear = 1'b0; cfg_read = 1'b0;
        wait_idle(300);

        // asynchronous reset in the middle of READ
        issue(1'b0, 1'b1);
        n = 0;
        while (dbg_state != ST_READ && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_read", dbg_state, ST_READ);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_enable", rwm_enable, 0);
        check("arst_rw", rwm_rw, 0);
        check("arst_clear", rwm_clear, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_frame_cnt", frame_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // fresh frame after reset
        exp_q.push_back(pack_exp(24'o3456, 8'd32, 4'd2, 2'd1, 1'b0, 2'd1));
        issue(1'b0, 1'b1);
        wait_idle(300);

        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
